captura_operandos_ula: RTL and testbench

// - Upstream operand-capture stage for the 8-bit bitwise ALU datapath (XOR/AND/OR units).
// - Captures A, then B, from board switches on debounced-free button presses.
// - Drives the captured values into the combinational operation unit.
// - Registers that unit's result and raises done.
// - Sits between board I/O (switches, push-buttons) and the 8-bit operation modules.

---
 rtl/ula_pkg.sv | 14 +
 rtl/detector_borda.sv | 34 +++
 rtl/captura_operandos_ula.sv | 99 +++++++++
 tb/tb_captura_operandos_ula.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the 8-bit bitwise ALU datapath: FSM state codes and default width.
// The display/LED decoder imports the same state codes.
package ula_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } estado_t;

endpackage

// File: rtl/detector_borda.sv
// Push-button front end: polarity normalisation, 2-flop synchroniser and rising-edge detector.
// Emits a single-cycle pulse per press; holding the button produces no repeats.
module detector_borda #(
    parameter bit BTN_ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic w_nivel;
    logic r_sinc1;
    logic r_sinc2;
    logic r_ant;

    assign w_nivel = BTN_ACT_LOW ? ~btn : btn;

    // Reset to 0 is the released level after normalisation, so no spurious pulse leaves reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_ant   <= 1'b0;
        end else begin
            r_sinc1 <= w_nivel;
            r_sinc2 <= r_sinc1;
            r_ant   <= r_sinc2;
        end
    end

    assign pulse = r_sinc2 & ~r_ant;

endmodule

// File: rtl/captura_operandos_ula.sv
// Operand-capture stage: captures A then B from the switches on confirm presses, registers the
// operation unit's result, raises done and counts completed operations. Cancel aborts to S_A.
module captura_operandos_ula
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter bit          BTN_ACT_LOW = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_confirm,
    input  logic             btn_cancel,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic [1:0]       state_led,
    output logic [CNT_W-1:0] op_count
);

    logic w_confirma;
    logic w_cancela;

    estado_t          r_estado;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic [CNT_W-1:0] r_cont;

    detector_borda #(.BTN_ACT_LOW(BTN_ACT_LOW)) u_det_confirma (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_confirm),
        .pulse (w_confirma)
    );

    detector_borda #(.BTN_ACT_LOW(BTN_ACT_LOW)) u_det_cancela (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_cancel),
        .pulse (w_cancela)
    );

    // Cancel is checked ahead of the state case so it overrides confirm and blocks the
    // S_EXEC result/done/count update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= S_A;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_cont   <= '0;
        end else if (w_cancela) begin
            r_estado <= S_A;
            r_done   <= 1'b0;
        end else begin
            case (r_estado)
                S_A: begin
                    if (w_confirma) begin
                        r_op_a   <= sw;
                        r_estado <= S_B;
                    end
                end
                S_B: begin
                    if (w_confirma) begin
                        r_op_b   <= sw;
                        r_estado <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= y_in;
                    r_done   <= 1'b1;
                    r_cont   <= r_cont + CNT_W'(1);
                    r_estado <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_confirma) begin
                        r_done   <= 1'b0;
                        r_estado <= S_A;
                    end
                end
                default: r_estado <= S_A;
            endcase
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign result    = r_result;
    assign done      = r_done;
    assign state_led = r_estado;
    assign op_count  = r_cont;

endmodule

// File: tb/tb_captura_operandos_ula.sv
// Directed self-checking bench for captura_operandos_ula with an XOR unit model on y_in.
module tb_captura_operandos_ula;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       btn_confirm;
    logic       btn_cancel;
    logic [7:0] y_in;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
    logic       done;
    logic [1:0] state_led;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    captura_operandos_ula #(
        .WIDTH       (8),
        .BTN_ACT_LOW (1'b1),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .btn_confirm (btn_confirm),
        .btn_cancel  (btn_cancel),
        .y_in        (y_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .result      (result),
        .done        (done),
        .state_led   (state_led),
        .op_count    (op_count)
    );

    assign y_in = op_a ^ op_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Press for two edges with sw glitching; sw equals v only at the edge that acts on the press.
    // Returns at the negedge right after that acting edge.
    task automatic press(input bit conf, input bit canc, input logic [7:0] v);
        @(negedge clk);
        if (conf) btn_confirm = 1'b0;
        if (canc) btn_cancel = 1'b0;
        sw = ~v;
        @(negedge clk);
        sw = v ^ 8'h5A;
        @(negedge clk);
        btn_confirm = 1'b1;
        btn_cancel  = 1'b1;
        sw = v;
        @(negedge clk);
        sw = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        press(1'b1, 1'b0, 8'h77);
        n_checks++;
        if (state_led !== 2'b01 || op_a !== 8'h77) begin
            n_fail++;
            $display("FAIL pre_reset_sb: state=%b op_a=%h required state=01 op_a=77", state_led, op_a);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state_led !== 2'b00 || op_a !== 8'h00 || op_b !== 8'h00 || result !== 8'h00 ||
            done !== 1'b0 || op_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: state=%b a=%h b=%h r=%h done=%b cnt=%h required all 0",
                     state_led, op_a, op_b, result, done, op_count);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state_led !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: state=%b done=%b required 00 0", state_led, done);
        end
    endtask

    task automatic test_full_op();
        press(1'b1, 1'b0, 8'hA5);
        n_checks++;
        if (op_a !== 8'hA5 || state_led !== 2'b01) begin
            n_fail++;
            $display("FAIL cap_a: op_a=%h state=%b required A5 01", op_a, state_led);
        end
        press(1'b1, 1'b0, 8'h0F);
        n_checks++;
        if (op_b !== 8'h0F || state_led !== 2'b10 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_b_exec: op_b=%h state=%b done=%b required 0F 10 0", op_b, state_led, done);
        end
        @(negedge clk);
        n_checks++;
        if (result !== 8'hAA || done !== 1'b1 || state_led !== 2'b11 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL show: result=%h done=%b state=%b cnt=%0d required AA 1 11 1",
                     result, done, state_led, op_count);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (result !== 8'hAA || done !== 1'b1 || state_led !== 2'b11) begin
            n_fail++;
            $display("FAIL show_hold: result=%h done=%b state=%b required AA 1 11", result, done, state_led);
        end
        press(1'b1, 1'b0, 8'h00);
        n_checks++;
        if (state_led !== 2'b00 || done !== 1'b0 || op_a !== 8'hA5 || op_b !== 8'h0F || result !== 8'hAA) begin
            n_fail++;
            $display("FAIL show_to_a: state=%b done=%b a=%h b=%h r=%h required 00 0 A5 0F AA",
                     state_led, done, op_a, op_b, result);
        end
    endtask

    task automatic test_held_button();
        @(negedge clk);
        btn_confirm = 1'b0;
        sw = 8'h3C;
        repeat (20) @(negedge clk);
        btn_confirm = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (state_led !== 2'b01 || op_a !== 8'h3C || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL held_once: state=%b op_a=%h cnt=%0d required 01 3C 1", state_led, op_a, op_count);
        end
    endtask

    task automatic test_cancel();
        press(1'b0, 1'b1, 8'hEE);
        n_checks++;
        if (state_led !== 2'b00 || op_a !== 8'h3C || done !== 1'b0 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL cancel_sb: state=%b a=%h done=%b cnt=%0d required 00 3C 0 1",
                     state_led, op_a, done, op_count);
        end
        press(1'b1, 1'b0, 8'h11);
        press(1'b1, 1'b1, 8'h22);
        n_checks++;
        if (state_led !== 2'b00 || op_a !== 8'h11 || op_b !== 8'h0F) begin
            n_fail++;
            $display("FAIL cancel_wins: state=%b a=%h b=%h required 00 11 0F", state_led, op_a, op_b);
        end
        // Cancel press trails confirm by one cycle, so it lands on the S_EXEC cycle.
        press(1'b1, 1'b0, 8'h33);
        @(negedge clk);
        btn_confirm = 1'b0;
        @(negedge clk);
        btn_cancel = 1'b0;
        @(negedge clk);
        btn_confirm = 1'b1;
        sw = 8'h44;
        @(negedge clk);
        btn_cancel = 1'b1;
        sw = 8'h99;
        @(negedge clk);
        n_checks++;
        if (state_led !== 2'b00 || op_b !== 8'h44 || result !== 8'hAA || done !== 1'b0 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL cancel_exec: state=%b b=%h r=%h done=%b cnt=%0d required 00 44 AA 0 1",
                     state_led, op_b, result, done, op_count);
        end
    endtask

    task automatic test_sw_glitch();
        press(1'b1, 1'b0, 8'hC3);
        n_checks++;
        if (op_a !== 8'hC3) begin
            n_fail++;
            $display("FAIL glitch_a: op_a=%h required C3", op_a);
        end
        press(1'b1, 1'b0, 8'h96);
        @(negedge clk);
        n_checks++;
        if (op_b !== 8'h96 || result !== 8'h55 || done !== 1'b1 || op_count !== 8'd2) begin
            n_fail++;
            $display("FAIL glitch_b: b=%h r=%h done=%b cnt=%0d required 96 55 1 2",
                     op_b, result, done, op_count);
        end
        press(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_wrap();
        logic [7:0] exp_cnt;
        logic [7:0] va;
        logic [7:0] vb;
        do_reset();
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            va = 8'(i);
            vb = 8'(i * 7 + 3);
            press(1'b1, 1'b0, va);
            press(1'b1, 1'b0, vb);
            @(negedge clk);
            exp_cnt = exp_cnt + 8'd1;
            n_checks++;
            if (op_count !== exp_cnt || result !== (va ^ vb) || done !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_op%0d: cnt=%0d r=%h done=%b required %0d %h 1",
                         i, op_count, result, done, exp_cnt, va ^ vb);
            end
            if (i != 255) press(1'b1, 1'b0, 8'h00);
        end
        n_checks++;
        if (op_count !== 8'd0 || done !== 1'b1 || state_led !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%0d done=%b state=%b required 0 1 11", op_count, done, state_led);
        end
    endtask

    initial begin
        reset       = 1'b1;
        sw          = 8'h00;
        btn_confirm = 1'b1;
        btn_cancel  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_full_op();
        test_held_button();
        test_cancel();
        test_sw_glitch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
